// File: rtl/bbox_msg_scheduler.sv
// Bounding-box report sequencer: at each report frame, bursts ID/TL/BR words per selected colour
// into the CPU message FIFO, or drops the whole frame when the burst would not fit.
module bbox_msg_scheduler #(
    parameter int MSG_INTERVAL = 6,
    parameter int FIFO_DEPTH   = 256,
    parameter int USEDW_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_done,
    input  logic [4:0]         bb_valid,
    input  logic [219:0]       bb_coords,
    input  logic [4:0]         col_enable,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_wrreq,
    output logic [31:0]        fifo_data,
    output logic               busy,
    output logic [15:0]        drop_count
);

    // state | meaning
    // IDLE  | waiting for a report frame
    // SCAN  | test colour idx for a selected box
    // ID    | write colour ID word
    // TL    | write top-left word
    // BR    | write bottom-right word, then next colour or IDLE
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_TL   = 3'd3;
    localparam logic [2:0] S_BR   = 3'd4;

    localparam int FC_W  = $clog2(MSG_INTERVAL) + 1;
    localparam int CMP_W = USEDW_W + 1;
    localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(MSG_INTERVAL - 1);
    localparam logic [CMP_W-1:0] SPACE_MAX = CMP_W'(FIFO_DEPTH - 1);

    logic [2:0]      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic [4:0]      sel_q, sel_d;
    logic [219:0]    coords_q, coords_d;

    logic            report;
    logic [4:0]      sel_now;
    logic [2:0]      pop;
    logic [3:0]      need;
    logic            space_ok;
    logic            drop_evt;
    logic [43:0]     box;
    logic [23:0]     id_word;

    always_comb begin
        sel_now = bb_valid & col_enable;
        pop = 3'd0;
        for (int i = 0; i < 5; i++) begin
            pop = pop + {2'b00, sel_now[i]};
        end
        need     = {1'b0, pop} + {pop, 1'b0};
        // widened compare so a near-full FIFO never wraps the free-space test
        space_ok = {1'b0, fifo_usedw} <= (SPACE_MAX - CMP_W'(need));
        report   = frame_done && (frame_cnt_q == '0);
        drop_evt = report && ((state_q != S_IDLE) || ((need != 4'd0) && !space_ok));
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        drop_count_d = drop_count_q;
        sel_d        = sel_q;
        coords_d     = coords_q;

        if (frame_done) begin
            frame_cnt_d = (frame_cnt_q == '0) ? FC_RELOAD : frame_cnt_q - 1'b1;
        end
        if (drop_evt && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (report && (need != 4'd0) && space_ok) begin
                    sel_d    = sel_now;
                    coords_d = bb_coords;
                    idx_d    = 3'd0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (sel_q[idx_q]) begin
                    state_d = S_ID;
                end else if (idx_q == 3'd4) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_ID: state_d = S_TL;
            S_TL: state_d = S_BR;
            S_BR: begin
                if (idx_q == 3'd4) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 3'd0;
            frame_cnt_q  <= '0;
            drop_count_q <= 16'd0;
            sel_q        <= 5'd0;
            coords_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_count_q <= drop_count_d;
            sel_q        <= sel_d;
            coords_q     <= coords_d;
        end
    end

    always_comb begin
        case (idx_q)
            3'd1:    begin box = coords_q[87:44];   id_word = 24'h594242; end
            3'd2:    begin box = coords_q[131:88];  id_word = 24'h474242; end
            3'd3:    begin box = coords_q[175:132]; id_word = 24'h424242; end
            3'd4:    begin box = coords_q[219:176]; id_word = 24'h504242; end
            default: begin box = coords_q[43:0];    id_word = 24'h524242; end
        endcase
    end

    always_comb begin
        fifo_wrreq = 1'b0;
        fifo_data  = 32'd0;
        case (state_q)
            S_ID: begin
                fifo_wrreq = 1'b1;
                fifo_data  = {8'h00, id_word};
            end
            S_TL: begin
                fifo_wrreq = 1'b1;
                fifo_data  = {5'b0, box[43:33], 5'b0, box[32:22]};
            end
            S_BR: begin
                fifo_wrreq = 1'b1;
                fifo_data  = {5'b0, box[21:11], 5'b0, box[10:0]};
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_bbox_msg_scheduler.sv
// Bench for bbox_msg_scheduler: directed scenarios plus random traffic, all checked every cycle
// against a schedule-based model of when each message word should appear.
module tb_bbox_msg_scheduler;

    localparam int MI = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_done;
    logic [4:0]   bb_valid;
    logic [219:0] bb_coords;
    logic [4:0]   col_enable;
    logic [7:0]   fifo_usedw;
    logic         fifo_wrreq;
    logic [31:0]  fifo_data;
    logic         busy;
    logic [15:0]  drop_count;

    bbox_msg_scheduler #(.MSG_INTERVAL(MI), .FIFO_DEPTH(256), .USEDW_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_done (frame_done),
        .bb_valid   (bb_valid),
        .bb_coords  (bb_coords),
        .col_enable (col_enable),
        .fifo_usedw (fifo_usedw),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: edge counter, frame counter, drops, and a map of cycle -> expected word
    int          k = 0;
    int          m_fcnt = 0;
    int          m_drop = 0;
    int          m_busy_end = -10;
    logic [31:0] m_words[int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [31:0] id_of(input int i);
        case (i)
            0: return 32'h00524242;
            1: return 32'h00594242;
            2: return 32'h00474242;
            3: return 32'h00424242;
            default: return 32'h00504242;
        endcase
    endfunction

    task automatic model_edge();
        logic [4:0]  sel;
        int          need;
        int          s;
        logic [43:0] b;
        if (reset) begin
            m_fcnt = 0;
            m_drop = 0;
            m_busy_end = -10;
            m_words.delete();
            return;
        end
        if (!frame_done) return;
        if (m_fcnt != 0) begin
            m_fcnt--;
            return;
        end
        m_fcnt = MI - 1;
        sel  = bb_valid & col_enable;
        need = 3 * $countones(sel);
        if (k - 1 < m_busy_end) begin
            if (m_drop != 65535) m_drop++;
        end else if (need == 0) begin
        end else if (int'(fifo_usedw) > 255 - need) begin
            if (m_drop != 65535) m_drop++;
        end else begin
            s = k;
            for (int i = 0; i < 5; i++) begin
                if (sel[i]) begin
                    b = bb_coords[44*i +: 44];
                    m_words[s+1] = id_of(i);
                    m_words[s+2] = {5'b0, b[43:33], 5'b0, b[32:22]};
                    m_words[s+3] = {5'b0, b[21:11], 5'b0, b[10:0]};
                    s += 4;
                end else begin
                    s += 1;
                end
            end
            m_busy_end = s;
        end
    endtask

    task automatic compare();
        logic        ew;
        logic [31:0] ed;
        ew = m_words.exists(k);
        ed = ew ? m_words[k] : 32'd0;
        check("wrreq", {31'd0, fifo_wrreq}, {31'd0, ew});
        check("data", fifo_data, ed);
        check("busy", {31'd0, busy}, {31'd0, (k < m_busy_end)});
        check("drop_count", {16'd0, drop_count}, m_drop[31:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic set_box(input int i, input int l, input int t, input int r, input int b);
        bb_coords[44*i +: 44] = {l[10:0], t[10:0], r[10:0], b[10:0]};
    endtask

    task automatic rand_boxes();
        for (int i = 0; i < 5; i++)
            set_box(i, $urandom_range(0, 2047), $urandom_range(0, 2047),
                    $urandom_range(0, 2047), $urandom_range(0, 2047));
    endtask

    initial begin
        reset      = 1'b1;
        frame_done = 1'b0;
        bb_valid   = 5'd0;
        col_enable = 5'h1F;
        fifo_usedw = 8'd0;
        bb_coords  = '0;
        ticks(3);
        reset = 1'b0;
        tick();

        // red-only burst
        bb_valid = 5'b00001;
        set_box(0, 10, 20, 30, 40);
        pulse();
        ticks(8);

        // reporting interval: seven pulses, bursts on first and seventh
        do_reset();
        for (int p = 0; p < 7; p++) begin
            bb_valid = 5'b00010;
            set_box(1, p, p + 1, p + 100, p + 200);
            pulse();
            ticks(12);
        end

        // insufficient space, then the boundary that just fits
        do_reset();
        bb_valid   = 5'b10110;
        rand_boxes();
        fifo_usedw = 8'd250;
        pulse();
        ticks(3);
        for (int p = 0; p < MI - 1; p++) pulse();
        fifo_usedw = 8'd246;
        pulse();
        fifo_usedw = 8'd0;
        ticks(20);

        // enable mask selects only green
        do_reset();
        bb_valid   = 5'b10101;
        col_enable = 5'b00100;
        set_box(2, 0, 0, 639, 479);
        pulse();
        col_enable = 5'h1F;
        ticks(10);

        // report frame while a full 5-box burst is in flight
        do_reset();
        bb_valid = 5'h1F;
        rand_boxes();
        pulse();
        bb_valid = 5'd0;
        for (int p = 0; p < MI; p++) pulse();
        ticks(20);

        // reset in the TL cycle of a red burst
        do_reset();
        bb_valid = 5'b00001;
        set_box(0, 1, 2, 3, 4);
        pulse();
        ticks(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ticks(6);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            frame_done = ($urandom_range(0, 2) == 0);
            bb_valid   = 5'($urandom);
            col_enable = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1F;
            fifo_usedw = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(236, 255))
                                                     : 8'($urandom_range(0, 255));
            reset      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) rand_boxes();
            tick();
        end
        reset      = 1'b0;
        frame_done = 1'b0;
        ticks(25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
